// File: rtl/rs_alu.sv
// Reservation station in front of the single-cycle ALU: holds dispatched ops until both operands are known.
// Latency: an operand-complete dispatch reaches oEX_en two edges later; a wakeup leads to issue one edge after capture.
// Backpressure: oDP_full stops dispatch; the ALU side takes one op per cycle with no back-pressure; rdy=0 freezes everything.
//
// Ports: clk/rst (async active-low); rdy global enable; iROB_clr flush;
//        iDP_* dispatch in, oDP_full; iEX_*/iSLB_* result broadcasts; oEX_* registered issue to the ALU.
module rs_alu #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int NICK_W = 4,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iROB_clr,
    input  logic              iDP_en,
    input  logic [31:0]       iDP_pc,
    input  logic [OP_W-1:0]   iDP_op,
    input  logic [31:0]       iDP_imm,
    input  logic [NICK_W-1:0] iDP_rd_nick,
    input  logic              iDP_rs1_rdy,
    input  logic [31:0]       iDP_rs1_dt,
    input  logic [NICK_W-1:0] iDP_rs1_nick,
    input  logic              iDP_rs2_rdy,
    input  logic [31:0]       iDP_rs2_dt,
    input  logic [NICK_W-1:0] iDP_rs2_nick,
    output logic              oDP_full,
    input  logic              iEX_en,
    input  logic [NICK_W-1:0] iEX_nick,
    input  logic [31:0]       iEX_dt,
    input  logic              iSLB_en,
    input  logic [NICK_W-1:0] iSLB_nick,
    input  logic [31:0]       iSLB_dt,
    output logic              oEX_en,
    output logic [31:0]       oEX_pc,
    output logic [OP_W-1:0]   oEX_op,
    output logic [31:0]       oEX_imm,
    output logic [NICK_W-1:0] oEX_rd_nick,
    output logic [31:0]       oEX_rs1_dt,
    output logic [31:0]       oEX_rs2_dt
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [OP_W-1:0]   op;
        logic [31:0]       imm;
        logic [NICK_W-1:0] rd_nick;
        logic              s1_rdy;
        logic [31:0]       s1_dt;
        logic [NICK_W-1:0] s1_nick;
        logic              s2_rdy;
        logic [31:0]       s2_dt;
        logic [NICK_W-1:0] s2_nick;
    } ent_t;

    logic [DEPTH-1:0]  busy_q, busy_d;
    ent_t              ent_q [DEPTH];
    ent_t              ent_d [DEPTH];

    logic              ex_en_q, ex_en_d;
    logic [31:0]       ex_pc_q, ex_pc_d;
    logic [OP_W-1:0]   ex_op_q, ex_op_d;
    logic [31:0]       ex_imm_q, ex_imm_d;
    logic [NICK_W-1:0] ex_rd_nick_q, ex_rd_nick_d;
    logic [31:0]       ex_rs1_dt_q, ex_rs1_dt_d;
    logic [31:0]       ex_rs2_dt_q, ex_rs2_dt_d;

    logic              iss_vld;
    logic [IDX_W-1:0]  iss_idx;
    logic [IDX_W-1:0]  free_idx;
    logic              dp_full;
    logic              dp_take;

    // Returns {ready, data} for one source after looking at both broadcasts.
    // EX is checked first so it wins if both carry the same tag.
    function automatic logic [32:0] snoop(
        input logic              src_rdy,
        input logic [31:0]       src_dt,
        input logic [NICK_W-1:0] src_nick,
        input logic              ex_en,
        input logic [NICK_W-1:0] ex_nick,
        input logic [31:0]       ex_dt,
        input logic              slb_en,
        input logic [NICK_W-1:0] slb_nick,
        input logic [31:0]       slb_dt
    );
        logic [32:0] res;
        res = {src_rdy, src_dt};
        if (!src_rdy) begin
            if (ex_en && (ex_nick == src_nick)) begin
                res = {1'b1, ex_dt};
            end else if (slb_en && (slb_nick == src_nick)) begin
                res = {1'b1, slb_dt};
            end
        end
        return res;
    endfunction

    assign dp_full  = &busy_q;
    assign oDP_full = dp_full;
    assign dp_take  = rdy && !iROB_clr && iDP_en && !dp_full;

    // Lowest-index issue candidate and lowest-index free slot. Both look only at
    // registered state, so a slot freed by this cycle's issue is not reused until next cycle.
    always_comb begin
        iss_vld  = 1'b0;
        iss_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (busy_q[i] && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
                iss_vld = 1'b1;
                iss_idx = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        busy_d       = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        ex_en_d      = 1'b0;
        ex_pc_d      = ex_pc_q;
        ex_op_d      = ex_op_q;
        ex_imm_d     = ex_imm_q;
        ex_rd_nick_d = ex_rd_nick_q;
        ex_rs1_dt_d  = ex_rs1_dt_q;
        ex_rs2_dt_d  = ex_rs2_dt_q;

        if (rdy && iROB_clr) begin
            busy_d = '0;
        end else if (rdy) begin
            if (iss_vld) begin
                busy_d[iss_idx] = 1'b0;
                ex_en_d         = 1'b1;
                ex_pc_d         = ent_q[iss_idx].pc;
                ex_op_d         = ent_q[iss_idx].op;
                ex_imm_d        = ent_q[iss_idx].imm;
                ex_rd_nick_d    = ent_q[iss_idx].rd_nick;
                ex_rs1_dt_d     = ent_q[iss_idx].s1_dt;
                ex_rs2_dt_d     = ent_q[iss_idx].s2_dt;
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i]) begin
                    {ent_d[i].s1_rdy, ent_d[i].s1_dt} = snoop(ent_q[i].s1_rdy, ent_q[i].s1_dt,
                        ent_q[i].s1_nick, iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt);
                    {ent_d[i].s2_rdy, ent_d[i].s2_dt} = snoop(ent_q[i].s2_rdy, ent_q[i].s2_dt,
                        ent_q[i].s2_nick, iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt);
                end
            end

            // New entry goes into a slot that was free at the start of the cycle, never the one being issued.
            if (dp_take) begin
                busy_d[free_idx]          = 1'b1;
                ent_d[free_idx].pc        = iDP_pc;
                ent_d[free_idx].op        = iDP_op;
                ent_d[free_idx].imm       = iDP_imm;
                ent_d[free_idx].rd_nick   = iDP_rd_nick;
                ent_d[free_idx].s1_nick   = iDP_rs1_nick;
                ent_d[free_idx].s2_nick   = iDP_rs2_nick;
                {ent_d[free_idx].s1_rdy, ent_d[free_idx].s1_dt} = snoop(iDP_rs1_rdy, iDP_rs1_dt,
                    iDP_rs1_nick, iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt);
                {ent_d[free_idx].s2_rdy, ent_d[free_idx].s2_dt} = snoop(iDP_rs2_rdy, iDP_rs2_dt,
                    iDP_rs2_nick, iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            ex_en_q      <= 1'b0;
            ex_pc_q      <= '0;
            ex_op_q      <= '0;
            ex_imm_q     <= '0;
            ex_rd_nick_q <= '0;
            ex_rs1_dt_q  <= '0;
            ex_rs2_dt_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            ex_en_q      <= ex_en_d;
            ex_pc_q      <= ex_pc_d;
            ex_op_q      <= ex_op_d;
            ex_imm_q     <= ex_imm_d;
            ex_rd_nick_q <= ex_rd_nick_d;
            ex_rs1_dt_q  <= ex_rs1_dt_d;
            ex_rs2_dt_q  <= ex_rs2_dt_d;
        end
    end

    assign oEX_en      = ex_en_q;
    assign oEX_pc      = ex_pc_q;
    assign oEX_op      = ex_op_q;
    assign oEX_imm     = ex_imm_q;
    assign oEX_rd_nick = ex_rd_nick_q;
    assign oEX_rs1_dt  = ex_rs1_dt_q;
    assign oEX_rs2_dt  = ex_rs2_dt_q;

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: dispatch, bypass, wakeup, full, stall, flush and async reset.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the following edges.
// Backpressure: exercises oDP_full and the rdy freeze.
module tb_rs_alu;

    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int NICK_W = 4;
    localparam int OP_W   = 6;

    localparam logic [OP_W-1:0] OP_ADD  = 6'h01;
    localparam logic [OP_W-1:0] OP_ADDI = 6'h02;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              iROB_clr;
    logic              iDP_en;
    logic [31:0]       iDP_pc;
    logic [OP_W-1:0]   iDP_op;
    logic [31:0]       iDP_imm;
    logic [NICK_W-1:0] iDP_rd_nick;
    logic              iDP_rs1_rdy;
    logic [31:0]       iDP_rs1_dt;
    logic [NICK_W-1:0] iDP_rs1_nick;
    logic              iDP_rs2_rdy;
    logic [31:0]       iDP_rs2_dt;
    logic [NICK_W-1:0] iDP_rs2_nick;
    logic              oDP_full;
    logic              iEX_en;
    logic [NICK_W-1:0] iEX_nick;
    logic [31:0]       iEX_dt;
    logic              iSLB_en;
    logic [NICK_W-1:0] iSLB_nick;
    logic [31:0]       iSLB_dt;
    logic              oEX_en;
    logic [31:0]       oEX_pc;
    logic [OP_W-1:0]   oEX_op;
    logic [31:0]       oEX_imm;
    logic [NICK_W-1:0] oEX_rd_nick;
    logic [31:0]       oEX_rs1_dt;
    logic [31:0]       oEX_rs2_dt;

    int vec_cnt = 0;
    int err_cnt = 0;

    rs_alu #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NICK_W(NICK_W), .OP_W(OP_W)) u_dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iROB_clr(iROB_clr),
        .iDP_en(iDP_en), .iDP_pc(iDP_pc), .iDP_op(iDP_op), .iDP_imm(iDP_imm),
        .iDP_rd_nick(iDP_rd_nick),
        .iDP_rs1_rdy(iDP_rs1_rdy), .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs1_nick(iDP_rs1_nick),
        .iDP_rs2_rdy(iDP_rs2_rdy), .iDP_rs2_dt(iDP_rs2_dt), .iDP_rs2_nick(iDP_rs2_nick),
        .oDP_full(oDP_full),
        .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
        .iSLB_en(iSLB_en), .iSLB_nick(iSLB_nick), .iSLB_dt(iSLB_dt),
        .oEX_en(oEX_en), .oEX_pc(oEX_pc), .oEX_op(oEX_op), .oEX_imm(oEX_imm),
        .oEX_rd_nick(oEX_rd_nick), .oEX_rs1_dt(oEX_rs1_dt), .oEX_rs2_dt(oEX_rs2_dt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dp(input logic [OP_W-1:0] op, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [NICK_W-1:0] rd,
                      input logic r1, input logic [31:0] d1, input logic [NICK_W-1:0] n1,
                      input logic r2, input logic [31:0] d2, input logic [NICK_W-1:0] n2);
        iDP_en       = 1'b1;
        iDP_op       = op;
        iDP_pc       = pc;
        iDP_imm      = imm;
        iDP_rd_nick  = rd;
        iDP_rs1_rdy  = r1;
        iDP_rs1_dt   = d1;
        iDP_rs1_nick = n1;
        iDP_rs2_rdy  = r2;
        iDP_rs2_dt   = d2;
        iDP_rs2_nick = n2;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; iROB_clr = 1'b0;
        iDP_en = 1'b0; iDP_pc = '0; iDP_op = '0; iDP_imm = '0; iDP_rd_nick = '0;
        iDP_rs1_rdy = 1'b0; iDP_rs1_dt = '0; iDP_rs1_nick = '0;
        iDP_rs2_rdy = 1'b0; iDP_rs2_dt = '0; iDP_rs2_nick = '0;
        iEX_en = 1'b0; iEX_nick = '0; iEX_dt = '0;
        iSLB_en = 1'b0; iSLB_nick = '0; iSLB_dt = '0;

        step(); step();
        chk("rst_en",   32'(oEX_en), 32'd0);
        chk("rst_full", 32'(oDP_full), 32'd0);
        chk("rst_pc",   oEX_pc, 32'd0);
        chk("rst_rs1",  oEX_rs1_dt, 32'd0);
        rst = 1'b1;
        step();

        // ADD 5+7, rd 3, both operands ready
        dp(OP_ADD, 32'h0000_1000, 32'd0, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        step();
        iDP_en = 1'b0;
        chk("add_e1_en", 32'(oEX_en), 32'd0);
        step();
        chk("add_en",  32'(oEX_en), 32'd1);
        chk("add_op",  32'(oEX_op), 32'(OP_ADD));
        chk("add_pc",  oEX_pc, 32'h0000_1000);
        chk("add_rs1", oEX_rs1_dt, 32'd5);
        chk("add_rs2", oEX_rs2_dt, 32'd7);
        chk("add_rd",  32'(oEX_rd_nick), 32'd3);
        step();
        chk("add_pulse", 32'(oEX_en), 32'd0);

        // ADDI waiting on nick 9; nick 8 must not wake it
        dp(OP_ADDI, 32'h0000_2000, 32'h10, 4'd4, 1'b0, 32'd0, 4'd9, 1'b1, 32'd0, 4'd0);
        step();
        iDP_en = 1'b0;
        iEX_en = 1'b1; iEX_nick = 4'd8; iEX_dt = 32'h55;
        step();
        chk("addi_wait_en", 32'(oEX_en), 32'd0);
        iEX_nick = 4'd9; iEX_dt = 32'h100;
        step();
        iEX_en = 1'b0;
        chk("addi_nick8_en", 32'(oEX_en), 32'd0);
        step();
        chk("addi_en",  32'(oEX_en), 32'd1);
        chk("addi_rs1", oEX_rs1_dt, 32'h100);
        chk("addi_imm", oEX_imm, 32'h10);
        chk("addi_rd",  32'(oEX_rd_nick), 32'd4);
        step();
        chk("addi_pulse", 32'(oEX_en), 32'd0);

        // Dispatch bypass from the SLB broadcast
        dp(OP_ADD, 32'h0000_3000, 32'd0, 4'd6, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd2);
        iSLB_en = 1'b1; iSLB_nick = 4'd2; iSLB_dt = 32'hDEAD;
        step();
        iDP_en = 1'b0; iSLB_en = 1'b0;
        chk("byp_e1_en", 32'(oEX_en), 32'd0);
        step();
        chk("byp_en",  32'(oEX_en), 32'd1);
        chk("byp_rs2", oEX_rs2_dt, 32'hDEAD);
        step();

        // Fill all 16 entries waiting on nick 1
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_notfull", 32'(oDP_full), 32'd0);
            dp(OP_ADD, 32'h100 + 32'(i), 32'(i), NICK_W'(i), 1'b0, 32'd0, 4'd1, 1'b1, 32'd2, 4'd0);
            step();
        end
        iDP_en = 1'b0;
        chk("full", 32'(oDP_full), 32'd1);
        // Overflow dispatch with ready operands: would issue if it were taken
        dp(OP_ADD, 32'hBAD0, 32'hBAD, 4'd15, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0);
        step();
        iDP_en = 1'b0;
        chk("ovf_en0", 32'(oEX_en), 32'd0);
        step();
        chk("ovf_en1", 32'(oEX_en), 32'd0);
        chk("ovf_full", 32'(oDP_full), 32'd1);
        iEX_en = 1'b1; iEX_nick = 4'd1; iEX_dt = 32'h11;
        step();
        iEX_en = 1'b0;
        chk("wake_en", 32'(oEX_en), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("drain_en",  32'(oEX_en), 32'd1);
            chk("drain_rd",  32'(oEX_rd_nick), 32'(i));
            chk("drain_imm", oEX_imm, 32'(i));
            chk("drain_rs1", oEX_rs1_dt, 32'h11);
            if (i == 0) chk("drain_full", 32'(oDP_full), 32'd0);
        end
        step();
        chk("drain_done", 32'(oEX_en), 32'd0);

        // Four entries become ready together, then a 3-cycle stall
        for (int i = 0; i < 4; i++) begin
            dp(OP_ADD, 32'h200 + 32'(i), 32'h40 + 32'(i), NICK_W'(i), 1'b0, 32'd0, 4'd5, 1'b1, 32'd3, 4'd0);
            step();
        end
        iDP_en = 1'b0;
        iEX_en = 1'b1; iEX_nick = 4'd5; iEX_dt = 32'h55;
        step();
        iEX_en = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_en",  32'(oEX_en), 32'd0);
            chk("stall_imm", oEX_imm, 32'd15);
        end
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("unstall_en",  32'(oEX_en), 32'd1);
            chk("unstall_imm", oEX_imm, 32'h40 + 32'(i));
        end
        step();
        chk("unstall_done", 32'(oEX_en), 32'd0);

        // Flush with one waiting and one ready entry pending, plus a dispatch in the flush cycle
        dp(OP_ADD, 32'h300, 32'hB0, 4'd7, 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0);
        step();
        dp(OP_ADD, 32'h304, 32'hA0, 4'd8, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        step();
        dp(OP_ADD, 32'h308, 32'hC0, 4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        iROB_clr = 1'b1;
        step();
        iROB_clr = 1'b0; iDP_en = 1'b0;
        chk("clr_en",   32'(oEX_en), 32'd0);
        chk("clr_full", 32'(oDP_full), 32'd0);
        iEX_en = 1'b1; iEX_nick = 4'd12; iEX_dt = 32'h12;
        step();
        iEX_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("clr_stale", 32'(oEX_en), 32'd0);
            step();
        end

        // Async reset while an op is on the issue port and another is pending
        dp(OP_ADD, 32'h400, 32'hD0, 4'd10, 1'b1, 32'd4, 4'd0, 1'b1, 32'd4, 4'd0);
        step();
        dp(OP_ADD, 32'h404, 32'hE0, 4'd11, 1'b1, 32'd4, 4'd0, 1'b1, 32'd4, 4'd0);
        step();
        iDP_en = 1'b0;
        chk("pre_rst_en",  32'(oEX_en), 32'd1);
        chk("pre_rst_imm", oEX_imm, 32'hD0);
        #2 rst = 1'b0;
        #1;
        chk("arst_en",  32'(oEX_en), 32'd0);
        chk("arst_imm", oEX_imm, 32'd0);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_en", 32'(oEX_en), 32'd0);
        end
        dp(OP_ADD, 32'h500, 32'hF0, 4'd13, 1'b1, 32'd6, 4'd0, 1'b1, 32'd8, 4'd0);
        step();
        iDP_en = 1'b0;
        step();
        chk("post_rst_iss", 32'(oEX_en), 32'd1);
        chk("post_rst_imm", oEX_imm, 32'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Reservation station feeding the combinational ALU execute unit.
- Accepts dispatched ALU, branch and jump ops from the issue stage, in ROB-tagged form. Each source operand arrives either as a value or as a producer nick.
- Snoops the ALU and SLB result broadcasts to capture missing operands. Issues at most one operand-complete entry per cycle to the ALU on a registered interface.
- Supplies the iRS_* side of the ALU interface.

Parameters:
- DEPTH, 16, number of entries (power of 2).
- IDX_W, 4, log2(DEPTH).
- NICK_W, 4, ROB tag width.
- OP_W, 6, internal opcode width; same encoding as the ALU.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global stall-enable; 0 freezes the block.
- iROB_clr  in  1  mispredict flush.
- iDP_en  in  1  dispatch valid.
- iDP_pc  in  32  instruction pc.
- iDP_op  in  OP_W  opcode.
- iDP_imm  in  32  immediate.
- iDP_rd_nick  in  NICK_W  destination ROB tag.
- iDP_rs1_rdy  in  1  1 = iDP_rs1_dt holds the value; 0 = wait on iDP_rs1_nick.
- iDP_rs1_dt  in  32  rs1 value.
- iDP_rs1_nick  in  NICK_W  rs1 producer tag.
- iDP_rs2_rdy  in  1  as rs1.
- iDP_rs2_dt  in  32  as rs1.
- iDP_rs2_nick  in  NICK_W  as rs1.
- oDP_full  out  1  no free entry.
- iEX_en  in  1  ALU result broadcast valid.
- iEX_nick  in  NICK_W  ALU result tag.
- iEX_dt  in  32  ALU result data.
- iSLB_en  in  1  load result broadcast valid.
- iSLB_nick  in  NICK_W  load result tag.
- iSLB_dt  in  32  load result data.
- oEX_en  out  1  issue valid to the ALU.
- oEX_pc  out  32  issued pc.
- oEX_op  out  OP_W  issued opcode.
- oEX_imm  out  32  issued immediate.
- oEX_rd_nick  out  NICK_W  issued destination tag.
- oEX_rs1_dt  out  32  issued rs1 value.
- oEX_rs2_dt  out  32  issued rs2 value.

Behaviour:
- Reset (rst=0, asynchronous):
  - All entries invalid.
  - oEX_en=0; all oEX_* data outputs 0.
  - oDP_full=0.
- Entry state: busy, pc, op, imm, rd_nick, and per source a ready flag, value and nick.
- Dispatch:
  - Taken when iDP_en=1 and rdy=1 and iROB_clr=0. Writes the lowest-index free entry.
  - Dispatch while oDP_full=1 is a protocol error: it is ignored and no entry changes.
- Dispatch bypass: a source arriving not-ready is written ready with the broadcast data when, in the same cycle, either:
  - iEX_en=1 with iEX_nick equal to its nick, or
  - iSLB_en=1 with iSLB_nick equal to its nick.
- Wakeup:
  - Each cycle with rdy=1, every busy entry's not-ready source whose nick matches an active broadcast latches that data and sets ready.
  - If both broadcasts match the same source, EX data wins; this is a legal case only when the nicks differ, so it is an upstream error.
- Issue selection:
  - Among busy entries with both sources ready at the start of the cycle, pick the lowest index.
  - On the clock edge, copy its fields to the oEX_* registers, set oEX_en=1, and free the entry.
  - If there is no candidate, oEX_en=0 on the next edge.
  - oEX_en is a one-cycle pulse per issued op; the ALU has no back-pressure.
- Eligibility timing:
  - An entry dispatched or woken in cycle N is first eligible for selection in cycle N+1.
  - Minimum dispatch-to-oEX_en latency is 2 edges for operand-complete dispatch.
- oDP_full: combinational; 1 when all DEPTH entries are busy. An entry freed by issue in cycle N is reusable from cycle N+1.
- Simultaneous dispatch and issue in the same cycle: both happen. The dispatched entry never uses the slot being freed that cycle.
- iROB_clr=1 (with rdy=1):
  - Clears all busy bits and sets oEX_en=0 on that edge.
  - Dispatch and wakeup are ignored that cycle.
  - Takes priority over all other events.
- rdy=0:
  - Entry state and oEX_* data hold.
  - oEX_en is forced to 0 on that edge, so an op is never presented twice.
  - Broadcasts during rdy=0 are not captured; producers stall under the same rdy.
- Ops reaching the ALU are treated uniformly; branch and JALR semantics belong to the ALU. All data is 32-bit with no truncation.

Test Plan:
- Reset, then dispatch ADD with rs1=5 and rs2=7 both ready, rd_nick=3: oEX_en=1 exactly two edges after dispatch, with op=ADD, rs1_dt=5, rs2_dt=7, rd_nick=3; the next cycle oEX_en=0.
- Dispatch ADDI with rs1 waiting on nick 9. Two cycles later pulse iEX_en with nick=9, dt=0x100: the entry wakes and issues the following cycle with oEX_rs1_dt=0x100. A broadcast on nick 8 causes no wakeup.
- Dispatch with rs2 waiting on nick 2 in the same cycle as iSLB_en with nick=2, dt=0xDEAD: bypass captures the value and the op issues two edges later with oEX_rs2_dt=0xDEAD.
- Dispatch 16 ops, all waiting on nick 1: oDP_full=1 and a 17th dispatch leaves state unchanged. Broadcast nick 1: the entries issue in index order 0..15, one per cycle, and oDP_full drops the cycle after the first issue.
- With 4 ready entries, drop rdy for 3 cycles: no oEX_en during the stall and no duplicate issue; all 4 issue after rdy returns. Then assert iROB_clr while entries are pending: oEX_en=0 and oDP_full=0 next cycle, and no stale op issues afterwards.
- Pull rst low while an entry is mid-issue: oEX_en=0 immediately (asynchronously), and no op issues after release until a new dispatch.
